// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and legality check for the alu_seq slice.
// Opcode 9 (MUL) is legal only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_LDI = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_t;

  function automatic logic op_legal(
    input logic [3:0] op
  );
`ifdef ALU_SEQ_MUL_EN
    return op <= OP_LDI;
`else
    return (op <= OP_LDI) && (op != OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Instruction handshake bundle between the instruction source and alu_seq.
// master = instruction source, slave = alu_seq.
interface alu_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);

  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [DATA_W-1:0] imm;

  modport master (
    output instr_valid,
    output opcode,
    output rd,
    output rs1,
    output rs2,
    output imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  opcode,
    input  rd,
    input  rs1,
    input  rs2,
    input  imm,
    output instr_ready
  );

endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: op -> {result, carry}.
// MUL and illegal opcodes yield zero here; the sequencer handles them.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): {carry, result} = {1'b0, a} + {1'b0, b};
      (op == OP_SUB): {carry, result} = {1'b0, a} - {1'b0, b};
      (op == OP_AND): result = a & b;
      (op == OP_OR):  result = a | b;
      (op == OP_XOR): result = a ^ b;
      (op == OP_NOT): result = ~a;
      (op == OP_SHL): begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      (op == OP_SHR): begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      (op == OP_MOV): result = a;
      (op == OP_LDI): result = imm;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Execution sequencer: accept, read operands, execute, write back to reg_file.
// Optional shift-add MUL (opcode 9) enabled by defining ALU_SEQ_MUL_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  alu_seq_if.slave          bus,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] d_out_a,
  input  logic [DATA_W-1:0] d_out_b,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] d_in,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_c
);

  state_t            state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              c_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  assign bus.instr_ready = (state == IDLE);

  alu_core #(.DATA_W(DATA_W)) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (alu_res),
    .carry  (alu_c)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]    mul_cnt;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      wr        <= 1'b0;
      wr_addr   <= '0;
      d_in      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mul_cnt   <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
`endif
    end else begin
      wr   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            op_q      <= bus.opcode;
            rd_q      <= bus.rd;
            imm_q     <= bus.imm;
            rd_addr_a <= bus.rs1;
            rd_addr_b <= bus.rs2;
            state     <= READ;
          end
        end
        READ: begin
          a_q   <= d_out_a;
          b_q   <= d_out_b;
          state <= EXEC;
          // illegal ops signal in the EXEC cycle, then skip WB
          if (!op_legal(op_q)) begin
            done <= 1'b1;
            err  <= 1'b1;
          end
`ifdef ALU_SEQ_MUL_EN
          mul_cnt <= CNT_W'(DATA_W - 1);
          acc     <= '0;
          mcand   <= {{DATA_W{1'b0}}, d_out_a};
          mplier  <= d_out_b;
`endif
        end
        EXEC: begin
          if (!op_legal(op_q)) begin
            state <= IDLE;
`ifdef ALU_SEQ_MUL_EN
          end else if (op_q == OP_MUL) begin
            if (mul_cnt == '0) begin
              d_in    <= acc_next[DATA_W-1:0];
              c_q     <= |acc_next[2*DATA_W-1:DATA_W];
              wr      <= 1'b1;
              done    <= 1'b1;
              wr_addr <= rd_q;
              state   <= WB;
            end else begin
              acc     <= acc_next;
              mcand   <= mcand << 1;
              mplier  <= mplier >> 1;
              mul_cnt <= mul_cnt - 1'b1;
            end
`endif
          end else begin
            d_in    <= alu_res;
            c_q     <= alu_c;
            wr      <= 1'b1;
            done    <= 1'b1;
            wr_addr <= rd_q;
            state   <= WB;
          end
        end
        WB: begin
          flag_z <= (d_in == '0);
          flag_c <= c_q;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table, scoreboard, corner sequences.
// Define ALU_SEQ_MUL_EN for both bench and RTL to exercise the MUL build.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [DW-1:0] imm;
    logic [DW-1:0] val;
    logic          c;
    logic          e;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [DW-1:0] d_out_a, d_out_b, d_in;
  logic          wr, done, err, flag_z, flag_c;
  logic          rf_clr = 1'b1;
  logic [DW-1:0] rf [8];

  always #5 clk = ~clk;

  alu_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  alu_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .d_out_a   (d_out_a),
    .d_out_b   (d_out_b),
    .wr        (wr),
    .wr_addr   (wr_addr),
    .d_in      (d_in),
    .done      (done),
    .err       (err),
    .flag_z    (flag_z),
    .flag_c    (flag_c)
  );

  // behavioural reg_file: combinational read, clocked write
  assign d_out_a = rf[rd_addr_a];
  assign d_out_b = rf[rd_addr_b];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wr) begin
      rf[wr_addr] <= d_in;
    end
  end

  int   n_chk = 0;
  int   n_pass = 0;
  vec_t cur_exp;
  vec_t sb[$];
  vec_t tv[$];
  logic exp_z = 1'b0;
  logic exp_c = 1'b0;
  bit   flag_pend = 1'b0;
  int   accepts = 0;
  int   busy_cyc = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endfunction

  function automatic vec_t mk(logic [3:0] op, int rd, int rs1, int rs2,
                              logic [DW-1:0] imm, logic [DW-1:0] val,
                              logic c, logic e);
    vec_t v;
    v.op = op; v.rd = AW'(rd); v.rs1 = AW'(rs1); v.rs2 = AW'(rs2);
    v.imm = imm; v.val = val; v.c = c; v.e = e;
    return v;
  endfunction

  // scoreboard: push on accept, pop and compare on done
  always @(negedge clk) begin
    if (reset) begin
      if (bus.instr_valid && bus.instr_ready) begin
        sb.push_back(cur_exp);
        accepts++;
      end
      if (bus.instr_valid && !bus.instr_ready) busy_cyc++;
      if (flag_pend) begin
        chk("flag_z", flag_z, exp_z);
        chk("flag_c", flag_c, exp_c);
        chk("wr_one_cycle", wr, 0);
        flag_pend = 1'b0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL done_unexpected: done=1 with empty scoreboard, required no done");
        end else begin
          vec_t e;
          e = sb.pop_front();
          chk("err", err, e.e);
          if (e.e) begin
            chk("wr_on_err", wr, 0);
            chk("flag_z_keep", flag_z, exp_z);
            chk("flag_c_keep", flag_c, exp_c);
          end else begin
            chk("wr", wr, 1);
            chk("wr_addr", wr_addr, e.rd);
            chk("d_in", d_in, e.val);
            exp_z = (e.val == '0);
            exp_c = e.c;
            flag_pend = 1'b1;
          end
        end
      end else begin
        if (wr) chk("wr_outside_wb", wr, 0);
        if (err) chk("err_without_done", err, 0);
      end
    end
  end

  task automatic send(input vec_t v);
    int g;
    g = 0;
    @(posedge clk); #1;
    cur_exp = v;
    bus.opcode = v.op;
    bus.rd = v.rd;
    bus.rs1 = v.rs1;
    bus.rs2 = v.rs2;
    bus.imm = v.imm;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    while (!bus.instr_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      n_chk++;
      $display("FAIL send_timeout: ready=0 after 100 cycles, required 1");
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || flag_pend || !bus.instr_ready) && g < 200) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    if (g >= 200) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d pending, required 0", sb.size());
    end
  endtask

  task automatic latency(input string nm, input int exp_k);
    int k;
    k = 0;
    while (!done && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, k, exp_k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    vec_t mulv;
    bus.instr_valid = 1'b0;
    bus.opcode = '0;
    bus.rd = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    bus.imm = '0;

`ifdef ALU_SEQ_MUL_EN
    mulv = mk(OP_MUL, 6, 0, 1, 16'h0, 16'h0060, 1'b1, 1'b0);
`else
    mulv = mk(OP_MUL, 6, 0, 1, 16'h0, 16'h0000, 1'b0, 1'b1);
`endif
    tv.push_back(mk(OP_LDI, 0, 0, 0, 16'h1234, 16'h1234, 1'b0, 1'b0));
    tv.push_back(mk(OP_LDI, 1, 0, 0, 16'h5678, 16'h5678, 1'b0, 1'b0));
    tv.push_back(mk(OP_ADD, 2, 0, 1, 16'h0,    16'h68AC, 1'b0, 1'b0));
    tv.push_back(mk(OP_LDI, 3, 0, 0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0));
    tv.push_back(mk(OP_ADD, 4, 3, 3, 16'h0,    16'hFFFE, 1'b1, 1'b0));
    tv.push_back(mk(OP_SUB, 5, 0, 0, 16'h0,    16'h0000, 1'b0, 1'b0));
    tv.push_back(mk(4'd15,  6, 0, 1, 16'h0,    16'h0000, 1'b0, 1'b1));
    tv.push_back(mk(OP_AND, 6, 0, 1, 16'h0,    16'h1230, 1'b0, 1'b0));
    tv.push_back(mk(OP_OR,  7, 0, 1, 16'h0,    16'h567C, 1'b0, 1'b0));
    tv.push_back(mk(OP_XOR, 6, 0, 1, 16'h0,    16'h444C, 1'b0, 1'b0));
    tv.push_back(mk(OP_NOT, 6, 3, 0, 16'h0,    16'h0000, 1'b0, 1'b0));
    tv.push_back(mk(OP_SHL, 6, 3, 0, 16'h0,    16'hFFFE, 1'b1, 1'b0));
    tv.push_back(mk(OP_SHR, 6, 0, 0, 16'h0,    16'h091A, 1'b0, 1'b0));
    tv.push_back(mk(OP_SUB, 6, 0, 1, 16'h0,    16'hBBBC, 1'b1, 1'b0));
    tv.push_back(mk(OP_MOV, 6, 1, 0, 16'h0,    16'h5678, 1'b0, 1'b0));
    tv.push_back(mulv);
    tv.push_back(mk(4'd11,  6, 0, 1, 16'h0,    16'h0000, 1'b0, 1'b1));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_wr", wr, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_flag_z", flag_z, 0);
    chk("rst_flag_c", flag_c, 0);
    chk("rst_rd_addr_a", rd_addr_a, 0);
    chk("rst_d_in", d_in, 0);
    @(negedge clk);
    reset = 1'b1;
    rf_clr = 1'b0;

    for (int i = 0; i < tv.size(); i++) send(tv[i]);
    drain();
    chk("reg2", rf[2], 16'h68AC);
    chk("reg4", rf[4], 16'hFFFE);
    chk("reg5", rf[5], 16'h0000);
    chk("reg7", rf[7], 16'h567C);

    send(mk(OP_ADD, 2, 0, 1, 16'h0, 16'h68AC, 1'b0, 1'b0));
    latency("lat_add", 2);
    drain();
    send(mulv);
`ifdef ALU_SEQ_MUL_EN
    latency("lat_mul", DW + 1);
    drain();
    chk("reg6_mul", rf[6], 16'h0060);
`else
    latency("lat_mul_err", 1);
    drain();
`endif

    // valid held for 8 cycles: accepts at edges 0 and 4 only
    @(posedge clk); #1;
    cur_exp = mk(OP_LDI, 6, 0, 0, 16'hABCD, 16'hABCD, 1'b0, 1'b0);
    bus.opcode = OP_LDI;
    bus.rd = 3'd6;
    bus.imm = 16'hABCD;
    accepts = 0;
    busy_cyc = 0;
    bus.instr_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    chk("burst_accepts", accepts, 2);
    chk("burst_ready_low", busy_cyc, 6);
    drain();
    chk("reg6_burst", rf[6], 16'hABCD);

    send(mk(OP_ADD, 7, 1, 3, 16'h0, 16'h0, 1'b0, 1'b0));
    chk("read_addr_a", rd_addr_a, 1);
    chk("read_addr_b", rd_addr_b, 3);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("abort_wr", wr, 0);
    chk("abort_done", done, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_wr_hold", wr, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    exp_z = 1'b0;
    exp_c = 1'b0;
    flag_pend = 1'b0;
    #1;
    chk("abort_ready", bus.instr_ready, 1);
    chk("abort_flag_z", flag_z, 0);
    chk("abort_reg7", rf[7], 16'h567C);
    chk("abort_reg2", rf[2], 16'h68AC);

    send(mk(OP_LDI, 7, 0, 0, 16'h0000, 16'h0000, 1'b0, 1'b0));
    drain();
    chk("reg7_ldi0", rf[7], 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
